// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills RV32I instruction memory and releases the core.
// Optional IMEM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte must match before the core is released.
module imem_loader #(
    parameter int IMEM_DEPTH_WORDS = 1024,
    parameter int ADDR_W           = $clog2(IMEM_DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    // state | meaning
    // HDR   | collecting the 4-byte little-endian word count
    // DATA  | assembling instruction words and writing them out
    // CKSUM | waiting for the XOR checksum byte (checksum build only)
    // DONE  | image committed, core released one cycle after entry
    // ERROR | bad header or checksum, core held in reset
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, DATA, CKSUM, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {HDR, DATA, DONE, ERROR} state_t;
`endif

    localparam logic [31:0]     DEPTH_32 = 32'(IMEM_DEPTH_WORDS);
    localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);

    state_t          state;
    logic [1:0]      byte_idx;
    logic [23:0]     byte_buf;
    logic [ADDR_W:0] word_count;
    logic [31:0]     asm_word;
    logic [ADDR_W:0] words_next;
    logic            rx_fire;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      xor_acc;
`endif

    assign rx_fire    = rx_valid && rx_ready;
    assign asm_word   = {rx_data, byte_buf};
    assign words_next = words_loaded + ONE_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR;
            byte_idx     <= 2'd0;
            byte_buf     <= '0;
            word_count   <= '0;
            rx_ready     <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_rst_n    <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc      <= 8'd0;
`endif
        end else begin
            imem_wr_en <= 1'b0;
            case (state)
                HDR: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Full 32-bit compare so oversized counts never alias into range
                            if (asm_word == 32'd0 || asm_word > DEPTH_32) begin
                                state      <= ERROR;
                                rx_ready   <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                state      <= DATA;
                                word_count <= asm_word[ADDR_W:0];
                            end
                        end else begin
                            byte_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                        end
                    end
                end
                DATA: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_acc  <= xor_acc ^ rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= words_loaded[ADDR_W-1:0];
                            imem_wr_data <= asm_word;
                            words_loaded <= words_next;
                            if (words_next == word_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state     <= CKSUM;
`else
                                state     <= DONE;
                                rx_ready  <= 1'b0;
                                load_done <= 1'b1;
`endif
                            end
                        end else begin
                            byte_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CKSUM: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        rx_ready <= 1'b0;
                        if (rx_data == xor_acc) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    rx_ready  <= 1'b0;
                    load_done <= 1'b1;
                    cpu_rst_n <= 1'b1;
                end
                ERROR: begin
                    rx_ready   <= 1'b0;
                    load_error <= 1'b1;
                    cpu_rst_n  <= 1'b0;
                end
                default: begin
                    // Unreachable encodings park safely with the core held in reset
                    state      <= ERROR;
                    rx_ready   <= 1'b0;
                    load_error <= 1'b1;
                    load_done  <= 1'b0;
                    cpu_rst_n  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes come from an image-level model, a monitor checks strobes.
// Build with IMEM_LOADER_CHECKSUM_EN defined to also exercise the checksum byte.
module tb_imem_loader;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    imem_loader #(.IMEM_DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          checks = 0;
    int          errors = 0;
    int          image_id = 0;
    bit          spacing_on = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every write strobe and checks timing relations
    initial begin : monitor
        wr_t  e;
        int   cyc;
        int   last_wr;
        int   seen_id;
        logic prev_wr;
        logic prev_cpu;
        cyc = 0; last_wr = -1; seen_id = -1; prev_wr = 1'b0; prev_cpu = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (seen_id != image_id) begin
                seen_id = image_id;
                last_wr = -1;
            end
            chk("done_error_exclusive", 32'(load_done && load_error), 32'd0);
            if (imem_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual_addr=%0d expected=no_write", imem_wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(imem_wr_addr), e.addr);
                    chk("wr_data", imem_wr_data, e.data);
                    if (spacing_on && last_wr >= 0)
                        chk("wr_spacing", 32'(cyc - last_wr), 32'd4);
                    last_wr = cyc;
                end
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (cpu_rst_n && !prev_cpu)
                chk("cpu_release_after_last_write", 32'(prev_wr), 32'd1);
`endif
            prev_wr  = imem_wr_en;
            prev_cpu = cpu_rst_n;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int idle;
        idle = 0;
        while (gap_pct > 0 && idle < 3 && $urandom_range(99) < gap_pct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
            idle++;
        end
        chk("rx_ready_during_load", 32'(rx_ready), 32'd1);
        if (rx_ready) begin
            rx_valid = 1'b1;
            rx_data  = b;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(imem_wr_addr), 32'd0);
        chk("rst_wr_data", imem_wr_data, 32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_words_loaded", 32'(words_loaded), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        image_id++;
        #1;
        chk("rx_ready_low_before_first_edge", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Model: a header count in 1..DEPTH yields one write per image word at sequential addresses
    task automatic run_image(input logic [31:0] count, input int gap_pct, input bit corrupt);
        bit          hdr_ok;
        bit          pass;
        logic [7:0]  x;
        logic [31:0] w;
        hdr_ok = (count != 32'd0) && (count <= 32'(DEPTH));
        x = 8'd0;
        spacing_on = (gap_pct == 0);
        if (hdr_ok) begin
            for (int i = 0; i < int'(count); i++) begin
                exp_q.push_back('{addr: 32'(i), data: img[i]});
                x = x ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        pass = hdr_ok && !corrupt;
`else
        pass = hdr_ok;
`endif
        for (int k = 0; k < 4; k++) send_byte(count[8*k +: 8], gap_pct);
        if (hdr_ok) begin
            for (int i = 0; i < int'(count); i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_pct);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(corrupt ? (x ^ 8'h01) : x, gap_pct);
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        chk("words_loaded", 32'(words_loaded), hdr_ok ? count : 32'd0);
        chk("load_done", 32'(load_done), 32'(pass));
        chk("load_error", 32'(load_error), 32'(!pass));
        chk("cpu_rst_n", 32'(cpu_rst_n), 32'(pass));
        chk("rx_ready_terminal", 32'(rx_ready), 32'd0);
        exp_q.delete();
        spacing_on = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        bit c;
        apply_reset();

        img = '{32'h0000_0013, 32'h0050_0093};
        run_image(32'd2, 0, 1'b0);

        apply_reset();
        run_image(32'd2, 50, 1'b0);

        img.delete();
        apply_reset();
        run_image(32'd0, 20, 1'b0);
        apply_reset();
        run_image(32'd1025, 0, 1'b0);
        apply_reset();
        run_image(32'h0001_0002, 20, 1'b0);

        // Abort partway through the first data word, then reload the whole image
        img = '{32'h0000_0013, 32'h0050_0093};
        apply_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        apply_reset();
        run_image(32'd2, 30, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        apply_reset();
        run_image(32'd2, 0, 1'b1);
`endif

        img = '{32'hDEAD_BEEF};
        apply_reset();
        run_image(32'd1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(12, 1));
            c = 1'($urandom_range(1));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            apply_reset();
            run_image(32'(n), 40, c);
        end

        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        apply_reset();
        run_image(32'(DEPTH), 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
